if_fetch_ctrl: RTL and testbench

Instruction-fetch stage controller: owns the PC, drives a synchronous-read instruction memory (1-cycle read latency), and delivers `if_inst`/`if_pc` to the IF/ID boundary, where the hazard detection unit inspects `if_inst`. It consumes the hazard unit's `load_stall` and `flush` outputs, plus the branch target from EX. It holds the current instruction across stalls with a one-entry hold buffer so no instruction is lost or duplicated. On redirect it squashes in-flight fetches. Saturating stall/flush counters are provided for debug.

---
 rtl/if_fetch_ctrl_if.sv | 28 ++
 rtl/if_fetch_ctrl.sv | 89 ++++++++
 tb/tb_if_fetch_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_if.sv
// rtl/if_fetch_ctrl_if.sv - fetch controller bundle: hazard inputs, imem bus, IF/ID outputs, debug counters
interface if_fetch_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             load_stall;
    logic             flush;
    logic [31:0]      br_addr;
    logic             imem_en;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic [31:0]      if_inst;
    logic [31:0]      if_pc;
    logic             if_valid;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Fetch controller side
    modport master (
        input  load_stall, flush, br_addr, imem_rdata,
        output imem_en, imem_addr, if_inst, if_pc, if_valid, stall_cnt, flush_cnt
    );

    // Pipeline / memory environment side
    modport slave (
        output load_stall, flush, br_addr, imem_rdata,
        input  imem_en, imem_addr, if_inst, if_pc, if_valid, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - instruction-fetch controller with PC, one-entry stall hold buffer and redirect squash
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int          CNT_W    = 16
) (
    input  logic          clk,
    input  logic          rstn,
    if_fetch_ctrl_if.master bus
);
    logic [31:0]      pc_q;
    logic             resp_valid;
    logic [31:0]      resp_pc;
    logic             hold_valid;
    logic [31:0]      hold_inst;
    logic [31:0]      hold_pc;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic [31:0]      inst_mux;
    logic [31:0]      pc_mux;
    logic             valid_mux;
    logic [31:0]      br_aligned;

    // Redirect target forced to a word boundary
    assign br_aligned = bus.br_addr & ~32'h3;

    assign bus.imem_addr = pc_q;
    assign bus.imem_en   = !bus.flush && !bus.load_stall;
    assign bus.if_inst   = inst_mux;
    assign bus.if_pc     = pc_mux;
    assign bus.if_valid  = valid_mux;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

    // IF/ID output select: held instruction first, then the arriving response, else a bubble
    always_comb begin
        inst_mux  = NOP_INST;
        pc_mux    = resp_pc;
        valid_mux = 1'b0;
        if (hold_valid) begin
            inst_mux  = hold_inst;
            pc_mux    = hold_pc;
            valid_mux = 1'b1;
        end else if (resp_valid) begin
            inst_mux  = bus.imem_rdata;
            pc_mux    = resp_pc;
            valid_mux = 1'b1;
        end
    end

    // PC, in-flight response tracking, hold buffer and saturating debug counters
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_q        <= RESET_PC;
            resp_valid  <= 1'b0;
            resp_pc     <= RESET_PC;
            hold_valid  <= 1'b0;
            hold_inst   <= NOP_INST;
            hold_pc     <= RESET_PC;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (bus.flush) begin
            // Squash whatever is in flight or held; the new target is fetched next cycle
            pc_q       <= br_aligned;
            resp_valid <= 1'b0;
            hold_valid <= 1'b0;
            if (flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end else if (bus.load_stall) begin
            // No request this cycle, so nothing arrives next cycle; park the presented instruction once
            resp_valid <= 1'b0;
            if (!hold_valid) begin
                hold_inst  <= inst_mux;
                hold_pc    <= pc_mux;
                hold_valid <= valid_mux;
            end
            if (stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end else begin
            pc_q       <= pc_q + 32'd4;
            resp_valid <= 1'b1;
            resp_pc    <= pc_q;
            hold_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - directed table-driven bench for if_fetch_ctrl
module tb_if_fetch_ctrl;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        rstn;
        logic        ls;
        logic        fl;
        logic [31:0] br;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_en;
        logic [31:0] e_addr;
        logic [15:0] e_sc;
        logic [15:0] e_fc;
    } vec_t;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   failures = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    if_fetch_ctrl_if #(.CNT_W(16)) bus ();

    if_fetch_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.master)
    );

    // Instruction memory with 1-cycle read latency; each word holds its own address
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= bus.imem_addr;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic ls, input logic fl, input logic [31:0] br,
                                input logic v, input logic [31:0] pc, input logic [31:0] inst,
                                input logic en, input logic [31:0] addr,
                                input logic [15:0] sc, input logic [15:0] fc);
        vec_t x;
        x.rstn = r; x.ls = ls; x.fl = fl; x.br = br;
        x.e_valid = v; x.e_pc = pc; x.e_inst = inst; x.e_en = en; x.e_addr = addr;
        x.e_sc = sc; x.e_fc = fc;
        vq.push_back(x);
    endfunction

    task automatic check_outputs(input string tag, input logic v, input logic [31:0] pc,
                                 input logic [31:0] inst, input logic en, input logic [31:0] addr,
                                 input logic [15:0] sc, input logic [15:0] fc);
        chk({tag, "_valid"}, {31'b0, bus.if_valid}, {31'b0, v});
        chk({tag, "_pc"},    bus.if_pc, pc);
        chk({tag, "_inst"},  bus.if_inst, inst);
        chk({tag, "_en"},    {31'b0, bus.imem_en}, {31'b0, en});
        chk({tag, "_addr"},  bus.imem_addr, addr);
        chk({tag, "_scnt"},  {16'b0, bus.stall_cnt}, {16'b0, sc});
        chk({tag, "_fcnt"},  {16'b0, bus.flush_cnt}, {16'b0, fc});
    endtask

    initial begin
        //   rstn ls fl br            valid pc            inst          en addr          sc fc
        // free run from reset
        add(1, 0, 0, 32'h0,         0, 32'h0,        NOP,          1, 32'h0,        0, 0);
        add(1, 0, 0, 32'h0,         1, 32'h0,        32'h0,        1, 32'h4,        0, 0);
        add(1, 0, 0, 32'h0,         1, 32'h4,        32'h4,        1, 32'h8,        0, 0);
        add(1, 0, 0, 32'h0,         1, 32'h8,        32'h8,        1, 32'hC,        0, 0);
        add(1, 0, 0, 32'h0,         1, 32'hC,        32'hC,        1, 32'h10,       0, 0);
        // 3-cycle stall while 0x10 is presented
        add(1, 1, 0, 32'h0,         1, 32'h10,       32'h10,       0, 32'h14,       0, 0);
        add(1, 1, 0, 32'h0,         1, 32'h10,       32'h10,       0, 32'h14,       1, 0);
        add(1, 1, 0, 32'h0,         1, 32'h10,       32'h10,       0, 32'h14,       2, 0);
        add(1, 0, 0, 32'h0,         1, 32'h10,       32'h10,       1, 32'h14,       3, 0);
        // flush to unaligned 0x103
        add(1, 0, 1, 32'h103,       1, 32'h14,       32'h14,       0, 32'h18,       3, 0);
        add(1, 0, 0, 32'h0,         0, 32'h14,       NOP,          1, 32'h100,      3, 1);
        add(1, 0, 0, 32'h0,         1, 32'h100,      32'h100,      1, 32'h104,      3, 1);
        // flush together with stall while holding
        add(1, 1, 0, 32'h0,         1, 32'h104,      32'h104,      0, 32'h108,      3, 1);
        add(1, 1, 1, 32'h200,       1, 32'h104,      32'h104,      0, 32'h108,      4, 1);
        add(1, 0, 0, 32'h0,         0, 32'h104,      NOP,          1, 32'h200,      4, 2);
        add(1, 0, 0, 32'h0,         1, 32'h200,      32'h200,      1, 32'h204,      4, 2);
        // back-to-back flushes, last one wins
        add(1, 0, 1, 32'h300,       1, 32'h204,      32'h204,      0, 32'h208,      4, 2);
        add(1, 0, 1, 32'h400,       0, 32'h204,      NOP,          0, 32'h300,      4, 3);
        add(1, 0, 0, 32'h0,         0, 32'h204,      NOP,          1, 32'h400,      4, 4);
        add(1, 0, 0, 32'h0,         1, 32'h400,      32'h400,      1, 32'h404,      4, 4);
        // reset pulse during an active stall
        add(1, 1, 0, 32'h0,         1, 32'h404,      32'h404,      0, 32'h408,      4, 4);
        add(0, 1, 0, 32'h0,         1, 32'h404,      32'h404,      0, 32'h408,      5, 4);
        add(1, 0, 0, 32'h0,         0, 32'h0,        NOP,          1, 32'h0,        0, 0);
        add(1, 0, 0, 32'h0,         1, 32'h0,        32'h0,        1, 32'h4,        0, 0);
        // PC wrap via redirect near the top of the address space
        add(1, 0, 1, 32'hFFFF_FFFB, 1, 32'h4,        32'h4,        0, 32'h8,        0, 0);
        add(1, 0, 0, 32'h0,         0, 32'h4,        NOP,          1, 32'hFFFF_FFF8, 0, 1);
        add(1, 0, 0, 32'h0,         1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1, 32'hFFFF_FFFC, 0, 1);
        add(1, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 32'h0,      0, 1);
        add(1, 0, 0, 32'h0,         1, 32'h0,        32'h0,        1, 32'h4,        0, 1);

        rstn = 1'b0;
        bus.load_stall = 1'b0;
        bus.flush = 1'b0;
        bus.br_addr = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_outputs("reset", 1'b0, 32'h0, NOP, 1'b1, 32'h0, 16'd0, 16'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < vq.size(); i++) begin
            rstn = vq[i].rstn;
            bus.load_stall = vq[i].ls;
            bus.flush = vq[i].fl;
            bus.br_addr = vq[i].br;
            @(negedge clk);
            check_outputs($sformatf("row%0d", i), vq[i].e_valid, vq[i].e_pc, vq[i].e_inst,
                          vq[i].e_en, vq[i].e_addr, vq[i].e_sc, vq[i].e_fc);
            @(posedge clk);
            #1;
        end

        // long stall saturates the stall counter while the held instruction stays put
        rstn = 1'b1;
        bus.flush = 1'b0;
        bus.load_stall = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        bus.load_stall = 1'b0;
        @(negedge clk);
        check_outputs("sat_release", 1'b1, 32'h4, 32'h4, 1'b1, 32'h8, 16'hFFFF, 16'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_outputs("sat_next", 1'b1, 32'h8, 32'h8, 1'b1, 32'hC, 16'hFFFF, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
